// File: rtl/counter_mod_n.sv
// Modulo-MODULUS up/down counter with clear, clamped load, combinational terminal count and registered wrap pulse.
// Optional prescaler on the count enable, compiled in with COUNTER_MOD_N_PRESCALE_EN.
module counter_mod_n #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 7,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_nx;
    logic             wrap_nx;
    logic             step_ok;

`ifdef COUNTER_MOD_N_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre;
    logic [PW-1:0] pre_nx;

    assign step_ok = (pre == PW'(PRESCALE - 1));

    always_comb begin
        pre_nx = pre;
        if (clr || load)
            pre_nx = '0;
        else if (en)
            pre_nx = step_ok ? '0 : pre + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pre <= '0;
        else
            pre <= pre_nx;
    end
`else
    // Legal PRESCALE is >= 1, so this is constant 1 in every legal build.
    assign step_ok = (PRESCALE >= 1);
`endif

    assign tc = en & step_ok & (up_dn ? (count == MAX) : (count == '0));

    always_comb begin
        count_nx = count;
        wrap_nx  = 1'b0;
        if (clr) begin
            count_nx = '0;
        end else if (load) begin
            count_nx = (load_val > MAX) ? MAX : load_val;
        end else if (en && step_ok) begin
            if (up_dn) begin
                if (count == MAX) begin
                    count_nx = '0;
                    wrap_nx  = 1'b1;
                end else begin
                    count_nx = count + 1'b1;
                end
            end else begin
                if (count == '0) begin
                    count_nx = MAX;
                    wrap_nx  = 1'b1;
                end else begin
                    count_nx = count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_nx;
            wrap  <= wrap_nx;
        end
    end

endmodule

// File: tb/tb_counter_mod_n.sv
// Directed bench for counter_mod_n: vector table plus async reset, cascade and prescaler sequences.
module tb_counter_mod_n;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, up_dn, clr, load;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       tc, wrap;

    logic       clr2;
    logic [3:0] count2;
    logic       tc2, wrap2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_mod_n #(.WIDTH(4), .MODULUS(7)) dut (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .count(count), .tc(tc), .wrap(wrap)
    );

    counter_mod_n #(.WIDTH(4), .MODULUS(7)) u2 (
        .clk(clk), .reset(reset), .en(tc), .up_dn(1'b1), .clr(clr2), .load(1'b0),
        .load_val(4'd0), .count(count2), .tc(tc2), .wrap(wrap2)
    );

`ifdef COUNTER_MOD_N_PRESCALE_EN
    logic       en3, clr3;
    logic [3:0] count3;
    logic       tc3, wrap3;

    counter_mod_n #(.WIDTH(4), .MODULUS(7), .PRESCALE(3)) u3 (
        .clk(clk), .reset(reset), .en(en3), .up_dn(1'b1), .clr(clr3), .load(1'b0),
        .load_val(4'd0), .count(count3), .tc(tc3), .wrap(wrap3)
    );
`endif

    typedef struct {
        logic       clr, load, en, up_dn;
        logic [3:0] load_val;
        logic [3:0] count;
        logic       wrap, tc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic c, logic l, logic e, logic u, logic [3:0] lv,
                                logic [3:0] ec, logic ew, logic et);
        vec_t v;
        v.clr = c; v.load = l; v.en = e; v.up_dn = u; v.load_val = lv;
        v.count = ec; v.wrap = ew; v.tc = et;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int nwrap;
        int seq3[7];

        reset = 1'b1; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0;
        load_val = 4'd0; clr2 = 1'b1;
`ifdef COUNTER_MOD_N_PRESCALE_EN
        en3 = 1'b0; clr3 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_count", count, 0);
        check("reset_wrap", wrap, 0);
        en = 1'b1; up_dn = 1'b0;
        #1 check("reset_tc_down_at_0", tc, 1);
        en = 1'b0; up_dn = 1'b1;
        reset = 1'b0;

        // Test 1: up count through wrap
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 0, 1, 1, 0, 4'((i) % 7), (i == 7), (i == 6)));
        // Test 2: load 2 then count down through wrap
        vecs.push_back(mk(0, 1, 0, 1, 2, 2, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 6, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 5, 0, 0));
        // Test 3: clamp with en ignored, clr beats load
        vecs.push_back(mk(0, 1, 1, 1, 11, 6, 0, 1));
        vecs.push_back(mk(1, 1, 1, 1, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 15, 6, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 5, 5, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 6, 6, 0, 0));
        // Direction change: two consecutive wrap steps
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 6, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1));

        foreach (vecs[i]) begin
            clr = vecs[i].clr; load = vecs[i].load; en = vecs[i].en;
            up_dn = vecs[i].up_dn; load_val = vecs[i].load_val;
            step();
            check($sformatf("vec%0d_count", i), count, vecs[i].count);
            check($sformatf("vec%0d_wrap", i), wrap, vecs[i].wrap);
            check($sformatf("vec%0d_tc", i), tc, vecs[i].tc);
        end

        // Test 4: async reset mid-cycle at count 4
        clr = 1'b1; load = 1'b0; en = 1'b0; up_dn = 1'b1;
        step();
        clr = 1'b0; en = 1'b1;
        repeat (4) step();
        check("pre_reset_count", count, 4);
        #2 reset = 1'b1;
        #1 check("async_reset_count", count, 0);
        check("async_reset_wrap", wrap, 0);
        reset = 1'b0;
        en = 1'b0; load = 1'b1; load_val = 4'd6;
        @(negedge clk);
        step();
        load = 1'b0; en = 1'b1;
        step();
        check("wrap_before_reset", wrap, 1);
        #2 reset = 1'b1;
        #1 check("async_reset_wrap_high", wrap, 0);
        check("async_reset_count2", count, 0);
        step();
        check("held_in_reset", count, 0);
        reset = 1'b0;
        step();
        check("restart_after_reset", count, 1);

        // Test 5: cascade of two stages
        en = 1'b0; clr = 1'b1; clr2 = 1'b1;
        step();
        clr = 1'b0; clr2 = 1'b0; en = 1'b1; up_dn = 1'b1;
        nwrap = 0;
        for (int i = 0; i < 49; i++) begin
            step();
            if (wrap2) nwrap++;
            if (i == 6) check("cascade_stage2_after7", count2, 1);
        end
        check("cascade_stage1", count, 0);
        check("cascade_stage2", count2, 0);
        check("cascade_wrap2_pulses", nwrap, 1);
        check("cascade_wrap2_last", wrap2, 1);
        en = 1'b0;

`ifdef COUNTER_MOD_N_PRESCALE_EN
        // Test 6: prescale by 3
        seq3 = '{0, 0, 0, 1, 1, 1, 2};
        clr3 = 1'b1;
        step();
        clr3 = 1'b0; en3 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            check($sformatf("prescale_seq%0d", i), count3, seq3[i]);
        end
        step();
        step();
        en3 = 1'b0;
        step();
        step();
        check("prescale_hold", count3, 2);
        en3 = 1'b1;
        step();
        check("prescale_stretched_step", count3, 3);
        en3 = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
